// File: rtl/gpu_pkg.sv
// gpu_pkg
//   Shared constants and the CPU write-port address decoder for the
//   mapache64 tile GPU (320x480 half-rate VGA scan-out of a 256x240 image).
//   Contents:
//     - VRAM_ADDR_WIDTH, GPU_CLK_PERIOD_PS
//     - horizontal / vertical visible, porch, sync and total counts
//     - image geometry (border width, image size, tile grid)
//     - memory-map base addresses
//     - wr_target_e and decode_addr(): byte address -> write target
package gpu_pkg;

    localparam int VRAM_ADDR_WIDTH   = 13;
    localparam int GPU_CLK_PERIOD_PS = 79444;  // 12.5875 MHz

    localparam int H_VISIBLE    = 320;
    localparam int H_FRONT      = 8;
    localparam int H_SYNC       = 48;
    localparam int H_BACK       = 24;
    localparam int H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;

    localparam int V_VISIBLE    = 480;
    localparam int V_FRONT      = 10;
    localparam int V_SYNC       = 2;
    localparam int V_BACK       = 33;
    localparam int V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

    localparam int BORDER_W  = 32;
    localparam int IMG_W     = 256;
    localparam int IMG_H     = 240;
    localparam int TILE_COLS = 32;
    localparam int TILE_ROWS = 30;
    localparam int NT_SIZE   = TILE_COLS * TILE_ROWS;

    localparam logic [15:0] PAL_BASE      = 16'h03C0;
    localparam logic [15:0] SCROLL_X_ADDR = 16'h03C4;
    localparam logic [15:0] SCROLL_Y_ADDR = 16'h03C5;
    localparam logic [15:0] PAT_BASE      = 16'h1000;
    localparam logic [15:0] PAT_LAST      = 16'h1FFF;

    typedef enum logic [2:0] {
        WR_NONE,
        WR_NT,
        WR_PAL,
        WR_SCROLL_X,
        WR_SCROLL_Y,
        WR_PAT
    } wr_target_e;

    // Anything not matched here is unmapped and must be dropped by the caller.
    function automatic wr_target_e decode_addr(input logic [15:0] addr);
        wr_target_e tgt;
        tgt = WR_NONE;
        if (addr < 16'(NT_SIZE))
            tgt = WR_NT;
        else if (addr >= PAL_BASE && addr < PAL_BASE + 16'd4)
            tgt = WR_PAL;
        else if (addr == SCROLL_X_ADDR)
            tgt = WR_SCROLL_X;
        else if (addr == SCROLL_Y_ADDR)
            tgt = WR_SCROLL_Y;
        else if (addr >= PAT_BASE && addr <= PAT_LAST)
            tgt = WR_PAT;
        return tgt;
    endfunction

endpackage

// File: rtl/gpu_vga_timing.sv
// gpu_vga_timing
//   Free-running 400x525 raster counters for half-rate 640x480@60 VGA.
//   Ports:
//     clk        in   pixel clock
//     rst_n      in   asynchronous active-low reset (counters -> 0)
//     hcount     out  0..399, wraps and advances vcount
//     vcount     out  0..524
//     hsync_raw  out  active-low, low for hcount 328..375 (unaligned to pipeline)
//     vsync_raw  out  active-low, low for vcount 490..491 (unaligned to pipeline)
//     visible    out  hcount < 320 and vcount < 480
module gpu_vga_timing
    import gpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    output logic [8:0] hcount,
    output logic [9:0] vcount,
    output logic       hsync_raw,
    output logic       vsync_raw,
    output logic       visible
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcount <= '0;
            vcount <= '0;
        end else if (hcount == 9'(H_TOTAL - 1)) begin
            hcount <= '0;
            vcount <= (vcount == 10'(V_TOTAL - 1)) ? '0 : vcount + 10'd1;
        end else begin
            hcount <= hcount + 9'd1;
        end
    end

    assign hsync_raw = !((hcount >= 9'(H_SYNC_START)) && (hcount < 9'(H_SYNC_END)));
    assign vsync_raw = !((vcount >= 10'(V_SYNC_START)) && (vcount < 10'(V_SYNC_END)));
    assign visible   = (hcount < 9'(H_VISIBLE)) && (vcount < 10'(V_VISIBLE));

endmodule

// File: rtl/gpu.sv
// gpu
//   Tile-based video generator for mapache64. The CPU writes VRAM through a
//   write-only byte port; the block scans out a 256x240 image of 8x8 2bpp
//   tiles, line-doubled and centred in a 320x480 half-rate VGA raster.
//   Optional feature macro: GPU_SCROLL_EN adds scroll_x (0x03C4) and
//   scroll_y (0x03C5, clamped to 239) registers; without it those addresses
//   are unmapped.
//   Ports:
//     clk_12_5875  in   pixel clock (sole clock)
//     rst          in   asynchronous active-low reset
//     r, g, b      out  2-bit colour, 0 outside the active image
//     hsync, vsync out  active-low syncs, delayed PIPE cycles like the colour
//     data         in   CPU write data
//     address      in   CPU write byte address (ADDR_W <= 16)
//     cs           in   write strobe, active-high
//   Memory map: 0x0000-0x03BF nametable, 0x03C0-0x03C3 palette (RRGGBB),
//   0x1000-0x1FFF patterns (16 bytes/tile: low plane rows, then high plane).
module gpu
    import gpu_pkg::*;
#(
    parameter int ADDR_W = VRAM_ADDR_WIDTH,
    parameter int PIPE   = 3   // colour path is three registers; keep at 3
) (
    input  logic              clk_12_5875,
    input  logic              rst,
    output logic [1:0]        r,
    output logic [1:0]        g,
    output logic [1:0]        b,
    output logic              hsync,
    output logic              vsync,
    input  logic [7:0]        data,
    input  logic [ADDR_W-1:0] address,
    input  logic              cs
);

    logic [8:0] hcount;
    logic [9:0] vcount;
    logic       hsync_raw;
    logic       vsync_raw;
    logic       visible;

    gpu_vga_timing u_timing (
        .clk       (clk_12_5875),
        .rst_n     (rst),
        .hcount    (hcount),
        .vcount    (vcount),
        .hsync_raw (hsync_raw),
        .vsync_raw (vsync_raw),
        .visible   (visible)
    );

    logic [15:0] addr_ext;
    wr_target_e  wr_target;

    assign addr_ext  = 16'(address);
    assign wr_target = cs ? decode_addr(addr_ext) : WR_NONE;

    // VRAM is never reset. Patterns are split by plane so the low and high
    // bytes of one tile row can be fetched in the same cycle.
    logic [7:0] nt_ram     [0:1023];
    logic [7:0] pat_lo_ram [0:2047];
    logic [7:0] pat_hi_ram [0:2047];

    always_ff @(posedge clk_12_5875) begin
        if (wr_target == WR_NT)
            nt_ram[addr_ext[9:0]] <= data;
        if (wr_target == WR_PAT) begin
            if (addr_ext[3])
                pat_hi_ram[{addr_ext[11:4], addr_ext[2:0]}] <= data;
            else
                pat_lo_ram[{addr_ext[11:4], addr_ext[2:0]}] <= data;
        end
    end

    logic [5:0] palette [4];

    always_ff @(posedge clk_12_5875 or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++)
                palette[i] <= '0;
        end else if (wr_target == WR_PAL) begin
            palette[addr_ext[1:0]] <= data[5:0];
        end
    end

    logic       in_image;
    logic [7:0] ix;
    logic [7:0] iy;
    logic [7:0] ix_s;
    logic [7:0] iy_s;

    assign in_image = visible && (hcount >= 9'(BORDER_W)) && (hcount < 9'(BORDER_W + IMG_W));
    assign ix       = 8'(hcount - 9'(BORDER_W));
    assign iy       = 8'(vcount >> 1);  // line doubling

`ifdef GPU_SCROLL_EN
    logic [7:0] scroll_x;
    logic [7:0] scroll_y;
    logic [8:0] iy_sum;

    function automatic logic [7:0] sat_scroll_y(input logic [7:0] val);
        return (val >= 8'(IMG_H)) ? 8'(IMG_H - 1) : val;
    endfunction

    always_ff @(posedge clk_12_5875 or negedge rst) begin
        if (!rst) begin
            scroll_x <= '0;
            scroll_y <= '0;
        end else begin
            if (wr_target == WR_SCROLL_X)
                scroll_x <= data;
            if (wr_target == WR_SCROLL_Y)
                scroll_y <= sat_scroll_y(data);
        end
    end

    // Horizontal wrap is the natural 8-bit overflow; vertical wraps at 240.
    assign ix_s = ix + scroll_x;

    always_comb begin
        iy_sum = {1'b0, iy} + {1'b0, scroll_y};
        iy_s   = (iy_sum >= 9'(IMG_H)) ? 8'(iy_sum - 9'(IMG_H)) : iy_sum[7:0];
    end
`else
    assign ix_s = ix;
    assign iy_s = iy;
`endif

    logic       vld_p0;
    logic       vld_p1;
    logic [7:0] tile_p0;
    logic [2:0] fine_x_p0;
    logic [2:0] fine_y_p0;
    logic [7:0] lo_p1;
    logic [7:0] hi_p1;
    logic [2:0] fine_x_p1;

    logic [PIPE-1:0] hsync_dly;
    logic [PIPE-1:0] vsync_dly;

    // Control path: valid and syncs are flushed by reset; data regs are not.
    always_ff @(posedge clk_12_5875 or negedge rst) begin
        if (!rst) begin
            vld_p0    <= 1'b0;
            vld_p1    <= 1'b0;
            hsync_dly <= '1;
            vsync_dly <= '1;
        end else begin
            vld_p0    <= in_image;
            vld_p1    <= vld_p0;
            hsync_dly <= {hsync_dly[PIPE-2:0], hsync_raw};
            vsync_dly <= {vsync_dly[PIPE-2:0], vsync_raw};
        end
    end

    // ---- stage p0: nametable fetch ----
    always_ff @(posedge clk_12_5875) begin
        tile_p0   <= nt_ram[{iy_s[7:3], ix_s[7:3]}];
        fine_x_p0 <= ix_s[2:0];
        fine_y_p0 <= iy_s[2:0];
    end

    // ---- stage p1: pattern fetch ----
    always_ff @(posedge clk_12_5875) begin
        lo_p1     <= pat_lo_ram[{tile_p0, fine_y_p0}];
        hi_p1     <= pat_hi_ram[{tile_p0, fine_y_p0}];
        fine_x_p1 <= fine_x_p0;
    end

    // ---- stage p2: palette lookup and output register ----
    logic [1:0] pix_idx;
    logic [5:0] pix_rgb;

    // A palette write landing on this edge is not seen until the next pixel.
    always_comb begin
        pix_idx = {hi_p1[3'd7 - fine_x_p1], lo_p1[3'd7 - fine_x_p1]};
        pix_rgb = palette[pix_idx];
    end

    always_ff @(posedge clk_12_5875 or negedge rst) begin
        if (!rst) begin
            r <= '0;
            g <= '0;
            b <= '0;
        end else if (vld_p1) begin
            r <= pix_rgb[5:4];
            g <= pix_rgb[3:2];
            b <= pix_rgb[1:0];
        end else begin
            r <= '0;
            g <= '0;
            b <= '0;
        end
    end

    assign hsync = hsync_dly[PIPE-1];
    assign vsync = vsync_dly[PIPE-1];

endmodule

// File: tb/tb_gpu.sv
// tb_gpu
//   Directed bench for the gpu top. Pixel (h,v) of a frame reaches the
//   registered outputs on edge v*400+h+3 counted from reset release; the
//   bench samples on the falling edge after that.
module tb_gpu;

    logic        clk;
    logic        rst;
    logic [1:0]  r;
    logic [1:0]  g;
    logic [1:0]  b;
    logic        hsync;
    logic        vsync;
    logic [7:0]  data;
    logic [12:0] address;
    logic        cs;
    logic [5:0]  rgb;

    int edges;
    int checks;
    int failures;

    gpu u_dut (
        .clk_12_5875 (clk),
        .rst         (rst),
        .r           (r),
        .g           (g),
        .b           (b),
        .hsync       (hsync),
        .vsync       (vsync),
        .data        (data),
        .address     (address),
        .cs          (cs)
    );

    assign rgb = {r, g, b};

    initial begin
        clk = 1'b0;
        forever #40 clk = ~clk;
    end

    always @(posedge clk or negedge rst) begin
        if (!rst)
            edges <= 0;
        else
            edges <= edges + 1;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // One write per call; called and returns on a falling edge.
    task automatic wr(input logic [12:0] a, input logic [7:0] d);
        cs      = 1'b1;
        address = a;
        data    = d;
        @(negedge clk);
        cs      = 1'b0;
    endtask

    task automatic at_pixel(input int h, input int v);
        int target;
        target = v * 400 + h + 3;
        while (edges < target)
            @(negedge clk);
        if (edges != target)
            check("pixel_late", edges, target);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        cs       = 1'b0;
        data     = '0;
        address  = '0;
        #5 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rgb", int'(rgb), 0);
        check("rst_hsync", int'(hsync), 1);
        check("rst_vsync", int'(vsync), 1);

        // Zero the nametable and tiles 0..2, then reset again.
        rst = 1'b1;
        for (int i = 0; i < 960; i++)
            wr(13'(i), 8'h00);
        for (int i = 0; i < 48; i++)
            wr(13'h1000 + 13'(i), 8'h00);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;

        wr(13'h0000, 8'h01);   // nt[0]  = tile 1
        wr(13'h0001, 8'h02);   // nt[1]  = tile 2
        wr(13'h0020, 8'h01);   // nt[32] = tile 1
        wr(13'h1010, 8'h80);   // tile 1 lo row 0
        wr(13'h1013, 8'h01);   // tile 1 lo row 3
        wr(13'h1028, 8'h40);   // tile 2 hi row 0
        wr(13'h03C0, 8'h30);   // red
        wr(13'h03C1, 8'h0C);   // green
        wr(13'h03C2, 8'h03);   // blue
        wr(13'h0800, 8'hAA);   // unmapped
        wr(13'h03C8, 8'h3F);   // unmapped
`ifndef GPU_SCROLL_EN
        wr(13'h03C4, 8'hFF);   // unmapped without scroll
        wr(13'h03C5, 8'hFF);
`endif

        at_pixel(31, 0);   check("border_l", int'(rgb), 0);
        at_pixel(32, 0);   check("tile_px0", int'(rgb), 'h0C);
        at_pixel(33, 0);   check("tile_px1", int'(rgb), 'h30);
        at_pixel(40, 0);   check("tile2_px0", int'(rgb), 'h30);
        at_pixel(41, 0);   check("hi_plane", int'(rgb), 'h03);
        at_pixel(287, 0);  check("last_img", int'(rgb), 'h30);
        at_pixel(288, 0);  check("border_r", int'(rgb), 0);
        at_pixel(320, 0);  check("hblank", int'(rgb), 0);
        at_pixel(327, 0);  check("hsync_pre", int'(hsync), 1);
        at_pixel(328, 0);  check("hsync_fall", int'(hsync), 0);
        at_pixel(375, 0);  check("hsync_end", int'(hsync), 0);
        at_pixel(376, 0);  check("hsync_rise", int'(hsync), 1);
        at_pixel(32, 1);   check("line_dbl", int'(rgb), 'h0C);
        at_pixel(41, 1);   check("line_dbl_hi", int'(rgb), 'h03);
        at_pixel(32, 2);   check("fine_y1", int'(rgb), 'h30);
        at_pixel(99, 2);   check("pre_coll", int'(rgb), 'h30);
        wr(13'h03C0, 8'h03);   // lands on the edge that outputs pixel 100
        at_pixel(100, 2);  check("coll_old", int'(rgb), 'h30);
        at_pixel(101, 2);  check("coll_new", int'(rgb), 'h03);
        at_pixel(0, 6);    check("vsync_hi", int'(vsync), 1);
        at_pixel(38, 6);   check("fine_y3_0", int'(rgb), 'h03);
        at_pixel(39, 6);   check("fine_y3_1", int'(rgb), 'h0C);
        at_pixel(32, 15);  check("row0_y7", int'(rgb), 'h03);
        at_pixel(32, 16);  check("tile_row1", int'(rgb), 'h0C);
        at_pixel(33, 16);  check("tile_row1_b", int'(rgb), 'h03);
        at_pixel(340, 16); check("hsync_mid", int'(hsync), 0);

        // Mid-frame reset: outputs clear at once, palette resets, VRAM kept.
        rst = 1'b0;
        #1;
        check("mid_rst_hsync", int'(hsync), 1);
        check("mid_rst_vsync", int'(vsync), 1);
        check("mid_rst_rgb", int'(rgb), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        wr(13'h03C2, 8'h03);
        at_pixel(32, 0);   check("pal_reset", int'(rgb), 0);
        at_pixel(41, 0);   check("vram_kept", int'(rgb), 'h03);
        at_pixel(327, 0);  check("restart_hs_pre", int'(hsync), 1);
        at_pixel(328, 0);  check("restart_hs", int'(hsync), 0);

`ifdef GPU_SCROLL_EN
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        wr(13'h03C4, 8'h08);   // scroll_x = 8
        wr(13'h03C5, 8'hFF);   // clamps to 239
        wr(13'h0001, 8'h01);   // nt[1] = tile 1
        wr(13'h03C0, 8'h30);
        wr(13'h03C1, 8'h0C);
        at_pixel(32, 0);   check("scr_row29", int'(rgb), 'h30);
        at_pixel(32, 2);   check("scr_wrap_y", int'(rgb), 'h0C);
        at_pixel(33, 2);   check("scr_px1", int'(rgb), 'h30);
        at_pixel(280, 2);  check("scr_wrap_x", int'(rgb), 'h0C);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
